// File: rtl/dm_ctl_pkg.sv
// Shared debug-module definitions: abstract command error codes, command
// types and the abstract-command sequencer state encoding.
package dm_ctl_pkg;

    localparam logic [2:0] CMDERR_NONE       = 3'd0;
    localparam logic [2:0] CMDERR_BUSY       = 3'd1;
    localparam logic [2:0] CMDERR_NOTSUP     = 3'd2;
    localparam logic [2:0] CMDERR_EXCEPTION  = 3'd3;
    localparam logic [2:0] CMDERR_HALTRESUME = 3'd4;

    localparam int         AC_CMDTYPE_MSB        = 31;
    localparam logic [7:0] AC_ACCESS_REGISTER    = 8'd0;
    localparam logic [7:0] AC_QUICK_ACCESS       = 8'd1;
    localparam logic [7:0] AC_ACCESS_MEMORY      = 8'd2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic cmd_supported(input logic [31:0] cmd);
        logic [7:0] cmdtype;
        cmdtype = cmd[AC_CMDTYPE_MSB -: 8];
        return (cmdtype == AC_ACCESS_REGISTER) || (cmdtype == AC_ACCESS_MEMORY);
    endfunction

endpackage

// File: rtl/dm_debug_if.sv
// Debug-module to hart run-control handshake.
interface dm_debug_if;
    logic        halt_req;
    logic        resume_req;
    logic        exec;
    logic [31:0] command;
    logic        halted;
    logic        done;
    logic        write;
    logic        error;

    modport requester (
        output halt_req, resume_req, exec, command,
        input  halted, done, write, error
    );

    modport responder (
        input  halt_req, resume_req, exec, command,
        output halted, done, write, error
    );
endinterface

// File: rtl/dm_abstract_seq.sv
// Abstract command sequencer: IDLE/EXEC/DONE handshake with the hart,
// command latch and sticky cmderr with write-1-to-clear.
module dm_abstract_seq
    import dm_ctl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dmactive,
    input  logic        halted,
    input  logic        command_wr,
    input  logic [31:0] command_wdata,
    input  logic        cmderr_w1c,
    input  logic [2:0]  cmderr_wdata,
    input  logic        done,
    input  logic        write,
    input  logic        error,
    output logic        exec,
    output logic        busy,
    output logic        data0_we,
    output logic [31:0] command,
    output logic [2:0]  cmderr
);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [2:0] err_set;
    logic       accept;

    always_comb begin
        state_nxt = state;
        err_set   = CMDERR_NONE;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (command_wr) begin
                    if (!halted) begin
                        err_set = CMDERR_HALTRESUME;
                    end else if (!cmd_supported(command_wdata)) begin
                        err_set = CMDERR_NOTSUP;
                    end else if (cmderr == CMDERR_NONE) begin
                        accept    = 1'b1;
                        state_nxt = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                if (done) begin
                    state_nxt = ST_DONE;
                    if (error) err_set = CMDERR_EXCEPTION;
                end
                if (command_wr) err_set = CMDERR_BUSY;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
                if (command_wr) err_set = CMDERR_BUSY;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // cmderr is sticky: a new error only lands on a clear field, and wins over a same-cycle clear
    always_ff @(posedge clk) begin
        if (!rst_n || !dmactive) begin
            state   <= ST_IDLE;
            command <= 32'd0;
            cmderr  <= CMDERR_NONE;
        end else begin
            state <= state_nxt;
            if (accept) command <= command_wdata;
            if ((err_set != CMDERR_NONE) && (cmderr == CMDERR_NONE)) begin
                cmderr <= err_set;
            end else if (cmderr_w1c) begin
                cmderr <= cmderr & ~cmderr_wdata;
            end
        end
    end

    assign exec     = (state == ST_EXEC);
    assign busy     = (state != ST_IDLE);
    assign data0_we = exec && done && write;

endmodule

// File: rtl/dm_ctl.sv
// Debug-module run control: halt/resume requests toward the hart and the
// abstract command sequencer, plus the status bits read back by the DMI.
module dm_ctl
    import dm_ctl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 dmactive,
    input  logic                 haltreq,
    input  logic                 resumereq_wr,
    input  logic                 command_wr,
    input  logic [31:0]          command_wdata,
    input  logic                 cmderr_w1c,
    input  logic [2:0]           cmderr_wdata,
    dm_debug_if.requester        debug_if,
    output logic                 allhalted,
    output logic                 allresumeack,
    output logic                 busy,
    output logic [2:0]           cmderr,
    output logic                 data0_we
);

    logic        resume_req;
    logic        ack_pend;
    logic        exec;
    logic [31:0] command;

    dm_abstract_seq u_seq (
        .clk           (clk),
        .rst_n         (rst_n),
        .dmactive      (dmactive),
        .halted        (debug_if.halted),
        .command_wr    (command_wr),
        .command_wdata (command_wdata),
        .cmderr_w1c    (cmderr_w1c),
        .cmderr_wdata  (cmderr_wdata),
        .done          (debug_if.done),
        .write         (debug_if.write),
        .error         (debug_if.error),
        .exec          (exec),
        .busy          (busy),
        .data0_we      (data0_we),
        .command       (command),
        .cmderr        (cmderr)
    );

    // Resume is held until the hart leaves halt; the acknowledge lands one cycle after the drop
    always_ff @(posedge clk) begin
        if (!rst_n || !dmactive) begin
            resume_req   <= 1'b0;
            ack_pend     <= 1'b0;
            allresumeack <= 1'b0;
        end else begin
            ack_pend <= 1'b0;
            if (ack_pend) allresumeack <= 1'b1;
            if (resume_req) begin
                if (!debug_if.halted) begin
                    resume_req <= 1'b0;
                    ack_pend   <= 1'b1;
                end
            end else if (resumereq_wr && debug_if.halted && !haltreq && !busy) begin
                resume_req   <= 1'b1;
                allresumeack <= 1'b0;
            end
        end
    end

    assign debug_if.halt_req   = haltreq && !resume_req;
    assign debug_if.resume_req = resume_req;
    assign debug_if.exec       = exec;
    assign debug_if.command    = command;
    assign allhalted           = debug_if.halted;

endmodule

// File: tb/tb_dm_ctl.sv
// Bench for dm_ctl: behavioural hart, transaction-level reference model and
// a scoreboard monitor that checks each abstract command the DUT issues.
module tb_dm_ctl;

    logic        clk = 1'b0;
    logic        rst_n, dmactive, haltreq, resumereq_wr, command_wr, cmderr_w1c;
    logic [31:0] command_wdata;
    logic [2:0]  cmderr_wdata;
    logic        allhalted, allresumeack, busy, data0_we;
    logic [2:0]  cmderr;

    always #5 clk = ~clk;

    dm_debug_if dbg ();

    dm_ctl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .dmactive      (dmactive),
        .haltreq       (haltreq),
        .resumereq_wr  (resumereq_wr),
        .command_wr    (command_wr),
        .command_wdata (command_wdata),
        .cmderr_w1c    (cmderr_w1c),
        .cmderr_wdata  (cmderr_wdata),
        .debug_if      (dbg),
        .allhalted     (allhalted),
        .allresumeack  (allresumeack),
        .busy          (busy),
        .cmderr        (cmderr),
        .data0_we      (data0_we)
    );

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] cmd;
        int          delay;
    } exp_t;

    exp_t        exp_q[$];
    int          hart_delay = 1;
    logic        hart_write = 1'b0;
    logic        hart_error = 1'b0;
    logic        late_done  = 1'b0;
    logic        abort_flag = 1'b0;
    logic [2:0]  m_cmderr   = 3'd0;

    // Behavioural hart: halts 3 cycles after a halt request, resumes 2 cycles
    // after a resume request, answers exec after hart_delay cycles.
    initial begin : hart
        int cnt, hcnt, rcnt;
        bit issued;
        cnt = 0; hcnt = 0; rcnt = 0; issued = 0;
        dbg.halted = 1'b0; dbg.done = 1'b0; dbg.write = 1'b0; dbg.error = 1'b0;
        forever begin
            @(posedge clk); #2;
            dbg.done = 1'b0; dbg.write = 1'b0; dbg.error = 1'b0;
            if (dbg.exec) begin
                cnt++;
                if (!issued && cnt == hart_delay) begin
                    dbg.done = 1'b1; dbg.write = hart_write; dbg.error = hart_error;
                    issued = 1;
                end
            end else begin
                cnt = 0; issued = 0;
            end
            if (late_done) begin
                dbg.done = 1'b1; dbg.write = 1'b1;
            end
            if (dbg.halt_req && !dbg.halted) begin
                hcnt++;
                if (hcnt == 3) begin dbg.halted = 1'b1; hcnt = 0; end
            end else hcnt = 0;
            if (dbg.resume_req && dbg.halted) begin
                rcnt++;
                if (rcnt == 2) begin dbg.halted = 1'b0; rcnt = 0; end
            end else rcnt = 0;
        end
    end

    // Scoreboard monitor
    initial begin : monitor
        logic prev_exec;
        int   exec_len;
        exp_t cur;
        bit   have;
        prev_exec = 1'b0; exec_len = 0; have = 0;
        cur.cmd = 32'd0; cur.delay = 0;
        forever begin
            @(negedge clk);
            check1("allhalted_mirror", allhalted, dbg.halted);
            if (dbg.exec && !prev_exec) begin
                exec_len = 0;
                if (exp_q.size() == 0) begin
                    check1("exec_unexpected", 1'b1, 1'b0);
                    have = 0;
                end else begin
                    cur  = exp_q.pop_front();
                    have = 1;
                    check32("exec_command", dbg.command, cur.cmd);
                    check1("busy_in_exec", busy, 1'b1);
                end
            end
            if (dbg.exec) exec_len++;
            check1("data0_we", data0_we, have && dbg.exec && dbg.done && dbg.write);
            if (!dbg.exec && prev_exec && have) begin
                if (!abort_flag) check32("exec_len", exec_len, cur.delay);
                have = 0;
            end
            prev_exec = dbg.exec;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic go_halted();
        int i;
        if (dbg.halted) return;
        haltreq = 1'b1;
        #1;
        check1("halt_req_level", dbg.halt_req, 1'b1);
        i = 0;
        while (!allhalted && i < 20) begin tick(); i++; end
        check1("allhalted_set", allhalted, 1'b1);
        resumereq_wr = 1'b1;
        tick();
        resumereq_wr = 1'b0;
        check1("resume_ignored_haltreq", dbg.resume_req, 1'b0);
        haltreq = 1'b0;
        #1;
        check1("halt_req_drop", dbg.halt_req, 1'b0);
        tick();
    endtask

    task automatic go_running();
        int i;
        if (!dbg.halted) return;
        haltreq = 1'b0;
        resumereq_wr = 1'b1;
        tick();
        resumereq_wr = 1'b0;
        check1("resume_req_set", dbg.resume_req, 1'b1);
        check1("resumeack_cleared", allresumeack, 1'b0);
        i = 0;
        while (dbg.resume_req && i < 20) begin tick(); i++; end
        check1("resume_req_drop", dbg.resume_req, 1'b0);
        check1("resumeack_not_yet", allresumeack, 1'b0);
        tick();
        check1("resumeack_set", allresumeack, 1'b1);
        check1("allhalted_clear", allhalted, 1'b0);
        resumereq_wr = 1'b1;
        tick();
        resumereq_wr = 1'b0;
        check1("resume_ignored_running", dbg.resume_req, 1'b0);
        check1("resumeack_sticky", allresumeack, 1'b1);
    endtask

    task automatic clear_err(input logic [2:0] mask);
        cmderr_w1c   = 1'b1;
        cmderr_wdata = mask;
        m_cmderr     = m_cmderr & ~mask;
        tick();
        cmderr_w1c   = 1'b0;
        check32("cmderr_after_clear", {29'd0, cmderr}, {29'd0, m_cmderr});
    endtask

    task automatic run_cmd(input logic [31:0] cmd, input int delay, input logic wr,
                           input logic er, input bit overlap);
        bit   accept;
        int   t;
        logic [7:0] ctype;
        ctype  = cmd[31:24];
        accept = (m_cmderr == 3'd0) && dbg.halted && (ctype == 8'd0 || ctype == 8'd2);
        if (m_cmderr == 3'd0) begin
            if (!dbg.halted)                          m_cmderr = 3'd4;
            else if (ctype != 8'd0 && ctype != 8'd2)  m_cmderr = 3'd2;
        end
        hart_delay = delay; hart_write = wr; hart_error = er;
        if (accept) exp_q.push_back('{cmd, delay});
        command_wdata = cmd;
        command_wr    = 1'b1;
        tick();
        command_wr = 1'b0;
        if (accept) begin
            check1("busy_after_accept", busy, 1'b1);
            t = 1;
            if (overlap) begin
                command_wdata = $urandom;
                command_wr    = 1'b1;
                tick();
                command_wr = 1'b0;
                t++;
                if (m_cmderr == 3'd0) m_cmderr = 3'd1;
            end
            while (t < delay + 1) begin tick(); t++; end
            check1("busy_in_done", busy, 1'b1);
            tick();
            check1("busy_dropped", busy, 1'b0);
            if (er && m_cmderr == 3'd0) m_cmderr = 3'd3;
        end else begin
            check1("busy_rejected", busy, 1'b0);
        end
        check32("cmderr", {29'd0, cmderr}, {29'd0, m_cmderr});
    endtask

    initial begin : stimulus
        rst_n = 1'b0; dmactive = 1'b1; haltreq = 1'b0; resumereq_wr = 1'b0;
        command_wr = 1'b0; command_wdata = 32'd0; cmderr_w1c = 1'b0; cmderr_wdata = 3'd0;
        repeat (3) tick();
        check1("rst_exec", dbg.exec, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check32("rst_cmderr", {29'd0, cmderr}, 32'd0);
        check1("rst_resumeack", allresumeack, 1'b0);
        check1("rst_resume_req", dbg.resume_req, 1'b0);
        check1("rst_halt_req", dbg.halt_req, 1'b0);
        check32("rst_command", dbg.command, 32'd0);
        rst_n = 1'b1;
        tick();

        go_halted();
        go_running();
        run_cmd(32'h0023_1001, 5, 1'b1, 1'b0, 0);
        clear_err(3'b111);

        go_halted();
        run_cmd(32'h0023_1001, 5, 1'b1, 1'b0, 0);
        run_cmd(32'h0212_3456, 3, 1'b0, 1'b1, 0);
        run_cmd(32'h0023_1001, 2, 1'b1, 1'b0, 0);
        clear_err(3'b111);
        run_cmd(32'h0023_1002, 2, 1'b1, 1'b0, 0);
        run_cmd(32'h0100_0000, 2, 1'b0, 1'b0, 0);
        clear_err(3'b111);
        run_cmd(32'h0023_1003, 4, 1'b1, 1'b0, 1);
        clear_err(3'b111);

        // dmactive drop mid-command; a late done must not write data0
        hart_delay = 30;
        exp_q.push_back('{32'h0023_1004, 30});
        command_wdata = 32'h0023_1004;
        command_wr = 1'b1;
        tick();
        command_wr = 1'b1;
        check1("abort_exec_started", dbg.exec, 1'b1);
        tick();
        command_wr = 1'b0;
        m_cmderr = 3'd1;
        check32("abort_cmderr_busy", {29'd0, cmderr}, {29'd0, m_cmderr});
        abort_flag = 1'b1;
        dmactive = 1'b0;
        tick();
        m_cmderr = 3'd0;
        check1("abort_exec", dbg.exec, 1'b0);
        check1("abort_busy", busy, 1'b0);
        check32("abort_cmderr", {29'd0, cmderr}, 32'd0);
        check32("abort_command", dbg.command, 32'd0);
        dmactive = 1'b1;
        tick();
        late_done = 1'b1;
        @(negedge clk);
        check1("late_done_no_we", data0_we, 1'b0);
        tick();
        late_done = 1'b0;
        tick();
        abort_flag = 1'b0;

        for (int it = 0; it < 200; it++) begin
            logic [31:0] cmd;
            if ($urandom_range(0, 5) == 0) begin
                if (dbg.halted) go_running();
                else            go_halted();
            end
            if ($urandom_range(0, 1) == 0) clear_err(3'($urandom_range(0, 7)));
            cmd = {6'd0, 2'($urandom_range(0, 3)), 24'($urandom)};
            run_cmd(cmd, $urandom_range(1, 6), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
        end

        repeat (5) tick();
        check32("queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
